// File: rtl/game_tick_ctrl_pkg.sv
// rtl/game_tick_ctrl_pkg.sv - shared state encodings, level width and scroll-period rule
package game_tick_ctrl_pkg;

    localparam int LEVEL_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_e;

    // Scroll speeds up by two base ticks per level but never drops below the floor.
    function automatic int unsigned scroll_period(input int unsigned lvl,
                                                  input int unsigned div0,
                                                  input int unsigned pmin);
        int unsigned dec;
        dec = 2 * lvl;
        if (div0 > dec + pmin) begin
            return div0 - dec;
        end
        return pmin;
    endfunction

endpackage

// File: rtl/game_tick_ctrl_if.sv
// rtl/game_tick_ctrl_if.sv - game control inputs and tick/status outputs of the scheduler
interface game_tick_ctrl_if;
    import game_tick_ctrl_pkg::*;

    logic               start;
    logic               pause;
    logic               game_over;
    logic               tick_base;
    logic               tick_player;
    logic               tick_scroll;
    logic               tick_anim;
    logic [LEVEL_W-1:0] level;
    logic               running;
    logic [1:0]         state;

    modport master (
        output start, pause, game_over,
        input  tick_base, tick_player, tick_scroll, tick_anim, level, running, state
    );

    modport slave (
        input  start, pause, game_over,
        output tick_base, tick_player, tick_scroll, tick_anim, level, running, state
    );

endinterface

// File: rtl/game_tick_ctrl_tick_div.sv
// rtl/game_tick_ctrl_tick_div.sv - enabled period divider with combinational fire and registered pulse
module tick_div #(
    parameter int CW = 17
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_i,
    input  logic          clr_i,
    input  logic [CW-1:0] period_i,
    output logic          fire_o,
    output logic          pulse_o
);

    logic [CW-1:0] count_q, count_d;
    logic          pulse_q, pulse_d;

    // ">=" lets a shortened period take effect on the very next enable.
    assign fire_o  = en_i && !clr_i && (count_q >= period_i - CW'(1));
    assign pulse_o = pulse_q;

    always_comb begin
        count_d = count_q;
        pulse_d = fire_o;
        if (clr_i) begin
            count_d = '0;
        end else if (fire_o) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            count_q <= count_d;
            pulse_q <= pulse_d;
        end
    end

endmodule

// File: rtl/game_tick_ctrl.sv
// rtl/game_tick_ctrl.sv - game-rate scheduler: run/pause FSM, base prescaler and derived tick strobes
module game_tick_ctrl
    import game_tick_ctrl_pkg::*;
#(
    parameter int PRESCALE    = 100000,
    parameter int CW          = 17,
    parameter int PLAYER_DIV  = 10,
    parameter int SCROLL_DIV0 = 20,
    parameter int SCROLL_MIN  = 4,
    parameter int ANIM_DIV    = 100,
    parameter int LEVEL_TICKS = 5000,
    parameter int LEVEL_MAX   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    game_tick_ctrl_if.slave  bus
);

    state_e             state_q, state_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic               in_idle;
    logic               run_en;
    logic               base_fire;
    logic               level_fire;
    logic               unused_level_pulse;
    logic [CW-1:0]      scroll_per;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.start) state_d = ST_RUN;
            ST_RUN:   if (bus.game_over) state_d = ST_OVER;
                      else if (bus.pause) state_d = ST_PAUSE;
            ST_PAUSE: if (bus.game_over) state_d = ST_OVER;
                      else if (bus.pause) state_d = ST_RUN;
            ST_OVER:  if (bus.start) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Counting needs RUN now and next, so a pause/over edge swallows a pending tick.
    assign in_idle = (state_q == ST_IDLE);
    assign run_en  = (state_q == ST_RUN) && (state_d == ST_RUN);

    assign scroll_per = CW'(scroll_period(32'(level_q), SCROLL_DIV0, SCROLL_MIN));

    always_comb begin
        level_d = level_q;
        if (in_idle && bus.start) begin
            level_d = '0;
        end else if (level_fire && (level_q < LEVEL_W'(LEVEL_MAX))) begin
            level_d = level_q + LEVEL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            level_q <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
        end
    end

    tick_div #(.CW(CW)) u_presc (
        .clk(clk), .rst_n(rst_n), .en_i(run_en), .clr_i(in_idle),
        .period_i(CW'(PRESCALE)), .fire_o(base_fire), .pulse_o(bus.tick_base)
    );

    tick_div #(.CW(CW)) u_player (
        .clk(clk), .rst_n(rst_n), .en_i(base_fire), .clr_i(in_idle),
        .period_i(CW'(PLAYER_DIV)), .fire_o(), .pulse_o(bus.tick_player)
    );

    tick_div #(.CW(CW)) u_scroll (
        .clk(clk), .rst_n(rst_n), .en_i(base_fire), .clr_i(in_idle),
        .period_i(scroll_per), .fire_o(), .pulse_o(bus.tick_scroll)
    );

    tick_div #(.CW(CW)) u_anim (
        .clk(clk), .rst_n(rst_n), .en_i(base_fire), .clr_i(in_idle),
        .period_i(CW'(ANIM_DIV)), .fire_o(), .pulse_o(bus.tick_anim)
    );

    tick_div #(.CW(CW)) u_level (
        .clk(clk), .rst_n(rst_n), .en_i(base_fire), .clr_i(in_idle),
        .period_i(CW'(LEVEL_TICKS)), .fire_o(level_fire), .pulse_o(unused_level_pulse)
    );

    assign bus.level   = level_q;
    assign bus.running = (state_q == ST_RUN);
    assign bus.state   = state_q;

endmodule

// File: tb/tb_game_tick_ctrl.sv
// tb/tb_game_tick_ctrl.sv - directed and random checks of game_tick_ctrl against a behavioural model
module tb_game_tick_ctrl;

    localparam int PRESCALE    = 4;
    localparam int PLAYER_DIV  = 2;
    localparam int SCROLL_DIV0 = 6;
    localparam int SCROLL_MIN  = 2;
    localparam int ANIM_DIV    = 3;
    localparam int LEVEL_TICKS = 5;
    localparam int LEVEL_MAX   = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    game_tick_ctrl_if bus ();

    game_tick_ctrl #(
        .PRESCALE(PRESCALE), .CW(17), .PLAYER_DIV(PLAYER_DIV),
        .SCROLL_DIV0(SCROLL_DIV0), .SCROLL_MIN(SCROLL_MIN), .ANIM_DIV(ANIM_DIV),
        .LEVEL_TICKS(LEVEL_TICKS), .LEVEL_MAX(LEVEL_MAX)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Model: run cycles since start, base ticks since start, base ticks since last scroll.
    int m_st, m_active, m_n, m_s, m_level;
    bit e_base, e_player, e_scroll, e_anim;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_active = 0; m_n = 0; m_s = 0; m_level = 0;
        e_base = 0; e_player = 0; e_scroll = 0; e_anim = 0;
    endtask

    function automatic int model_scroll_period(input int lvl);
        int p;
        p = SCROLL_DIV0 - 2 * lvl;
        if (p < SCROLL_MIN) p = SCROLL_MIN;
        return p;
    endfunction

    task automatic model_edge(input bit s, input bit p, input bit g);
        int nst;
        nst = m_st;
        case (m_st)
            0: if (s) nst = 1;
            1: if (g) nst = 3; else if (p) nst = 2;
            2: if (g) nst = 3; else if (p) nst = 1;
            default: if (s) nst = 0;
        endcase
        e_base = 0; e_player = 0; e_scroll = 0; e_anim = 0;
        if (m_st == 0) begin
            m_active = 0; m_n = 0; m_s = 0;
            if (s) m_level = 0;
        end else if (m_st == 1 && nst == 1) begin
            m_active++;
            if (m_active % PRESCALE == 0) begin
                int per;
                per      = model_scroll_period(m_level);
                e_base   = 1;
                m_n++;
                e_player = (m_n % PLAYER_DIV == 0);
                e_anim   = (m_n % ANIM_DIV == 0);
                m_s++;
                if (m_s >= per) begin
                    e_scroll = 1;
                    m_s      = 0;
                end
                m_level = (m_n / LEVEL_TICKS > LEVEL_MAX) ? LEVEL_MAX : m_n / LEVEL_TICKS;
            end
        end
        m_st = nst;
    endtask

    task automatic check_all();
        chk("state",       32'(bus.state),       32'(m_st));
        chk("running",     32'(bus.running),     32'(m_st == 1));
        chk("level",       32'(bus.level),       32'(m_level));
        chk("tick_base",   32'(bus.tick_base),   32'(e_base));
        chk("tick_player", 32'(bus.tick_player), 32'(e_player));
        chk("tick_scroll", 32'(bus.tick_scroll), 32'(e_scroll));
        chk("tick_anim",   32'(bus.tick_anim),   32'(e_anim));
    endtask

    task automatic step(input bit s, input bit p, input bit g);
        @(negedge clk);
        bus.start = s; bus.pause = p; bus.game_over = g;
        @(posedge clk);
        cyc++;
        model_edge(s, p, g);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.start = 1'b0; bus.pause = 1'b0; bus.game_over = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_all();
    endtask

    initial begin
        bus.start = 1'b0; bus.pause = 1'b0; bus.game_over = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_all();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step(0, 0, 0);

        // Long run through every level, then start ignored while running.
        step(1, 0, 0);
        chk("running_after_start", 32'(bus.running), 32'd1);
        repeat (90) step(0, 0, 0);
        chk("level_saturated", 32'(bus.level), 32'(LEVEL_MAX));
        step(1, 0, 0);
        repeat (10) step(0, 0, 0);

        do_reset();
        repeat (6) step(0, 0, 0);

        // Pause two clocks into a prescale period, resume, count continues.
        step(1, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 1, 0);
        repeat (5) step(0, 0, 0);
        step(1, 0, 0);
        step(0, 1, 0);
        step(0, 0, 0);
        chk("resume_no_early_base", 32'(bus.tick_base), 32'd0);
        step(0, 0, 0);
        chk("resume_first_base", 32'(bus.tick_base), 32'd1);
        repeat (40) step(0, 0, 0);

        // game_over wins over pause; level survives OVER->IDLE, cleared on start.
        step(0, 1, 1);
        chk("over_state", 32'(bus.state), 32'd3);
        repeat (8) step(0, 0, 0);
        step(0, 1, 0);
        step(1, 0, 0);
        chk("idle_level_held", 32'(bus.level), 32'(m_level));
        repeat (3) step(0, 0, 0);
        step(1, 0, 0);
        chk("level_cleared", 32'(bus.level), 32'd0);

        repeat (700) begin
            int r;
            r = int'($urandom_range(0, 199));
            step(r < 8, (r >= 8 && r < 12) || r == 199, r == 12 || r == 199);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
